// File: rtl/t4_4_norm_shift_if.sv
// t4_4_norm_shift_if: T4_3 -> T4_4 -> T5 handshake and data bundle.
// master drives the T4_3 side and out_ready, slave is the stage itself.
interface t4_4_norm_shift_if #(
  parameter int SIDE_W = 46,
  parameter int P_W    = 74
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        cont_T4_3;
  logic [P_W-1:0]    p_reg_T4_3;
  logic [9:0]        sh_num_T4_3;
  logic [1:0]        esh_T4_3;
  logic [1:0]        revising_T4_3;
  logic [SIDE_W-1:0] side_T4_3;
  logic              out_valid;
  logic              out_ready;
  logic [P_W-1:0]    norm_T4_4;
  logic [2:0]        cont_T4_4;
  logic [1:0]        zero_T4_4;
  logic [SIDE_W-1:0] side_T4_4;

  modport master (
    output in_valid, cont_T4_3, p_reg_T4_3, sh_num_T4_3,
    output esh_T4_3, revising_T4_3, side_T4_3, out_ready,
    input  in_ready, out_valid, norm_T4_4, cont_T4_4,
    input  zero_T4_4, side_T4_4
  );

  modport slave (
    input  in_valid, cont_T4_3, p_reg_T4_3, sh_num_T4_3,
    input  esh_T4_3, revising_T4_3, side_T4_3, out_ready,
    output in_ready, out_valid, norm_T4_4, cont_T4_4,
    output zero_T4_4, side_T4_4
  );
endinterface

// File: rtl/t4_4_norm_shift.sv
// t4_4_norm_shift: T4_4 left-normaliser of the multiply-add pipeline.
// Define T4_4_SKID_EN for a 2-entry skid buffer with registered in_ready.
module t4_4_norm_shift #(
  parameter int SIDE_W = 46,
  parameter int P_W    = 74
) (
  input logic              clk,
  input logic              rst,
  t4_4_norm_shift_if.slave bus
);
  localparam int LW = P_W / 2;

  typedef struct packed {
    logic [P_W-1:0]    norm;
    logic [2:0]        cont;
    logic [1:0]        zero;
    logic [SIDE_W-1:0] side;
  } res_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t        state, state_n;
  res_t          res, main_q;
  logic          push, pop, rdy, valid;
  logic          is_full, is_dual;
  logic [6:0]    amt_f;
  logic [5:0]    amt0, amt1;
  logic [LW-1:0] lo, hi;
  logic [P_W-1:0] p;

  // Normalise the incoming significand; each lane shifts in isolation
  always_comb begin
    p = bus.p_reg_T4_3;
    is_full = (bus.cont_T4_3 == 3'd0) || (bus.cont_T4_3 == 3'd2);
    is_dual = (bus.cont_T4_3 == 3'd1);
    amt_f = {1'b0, bus.esh_T4_3[0] ? bus.sh_num_T4_3[5:0] : 6'd0}
          + {6'd0, bus.revising_T4_3[0]};
    amt0 = {1'b0, bus.esh_T4_3[0] ? bus.sh_num_T4_3[4:0] : 5'd0}
         + {5'd0, bus.revising_T4_3[0]};
    amt1 = {1'b0, bus.esh_T4_3[1] ? bus.sh_num_T4_3[9:5] : 5'd0}
         + {5'd0, bus.revising_T4_3[1]};
    lo = p[LW-1:0] << amt0;
    hi = p[P_W-1:LW] << amt1;
    res = '0;
    res.cont = bus.cont_T4_3;
    res.side = bus.side_T4_3;
    res.zero = 2'b11;
    unique case (1'b1)
      is_full: begin
        res.norm = p << amt_f;
        res.zero = {2{p == '0}};
      end
      is_dual: begin
        res.norm = {hi, lo};
        res.zero = {p[P_W-1:LW] == '0, p[LW-1:0] == '0};
      end
      default: ;
    endcase
  end

  assign valid = (state != EMPTY);
  assign push  = bus.in_valid && rdy;
  assign pop   = valid && bus.out_ready;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = valid;
  assign bus.norm_T4_4 = main_q.norm;
  assign bus.cont_T4_4 = main_q.cont;
  assign bus.zero_T4_4 = main_q.zero;
  assign bus.side_T4_4 = main_q.side;

  // Occupancy next state from push/pop
  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY: if (push) state_n = ONE;
      ONE: begin
        if (pop && !push) state_n = EMPTY;
`ifdef T4_4_SKID_EN
        if (push && !pop) state_n = TWO;
`endif
      end
      TWO:     if (pop) state_n = ONE;
      default: state_n = EMPTY;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

`ifdef T4_4_SKID_EN
  res_t skid_q;
  logic rdy_q;

  assign rdy = rdy_q;

  // Output and skid entries; ready is registered to cut out_ready timing
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      rdy_q <= (state_n != TWO);
      unique case (state)
        EMPTY: if (push) main_q <= res;
        ONE: begin
          if (push && !pop)     skid_q <= res;
          else if (push && pop) main_q <= res;
        end
        TWO:     if (pop) main_q <= skid_q;
        default: ;
      endcase
    end
  end
`else
  assign rdy = !valid || bus.out_ready;

  // Single output register, reloaded on every accepted input
  always_ff @(posedge clk) begin
    if (rst)       main_q <= '0;
    else if (push) main_q <= res;
  end
`endif
endmodule

// File: tb/tb_t4_4_norm_shift.sv
// tb_t4_4_norm_shift: vector table plus scoreboard for t4_4_norm_shift.
// Works with or without T4_4_SKID_EN.
module tb_t4_4_norm_shift;
  localparam int NV = 15;

  typedef struct {
    logic [2:0]  cont;
    logic [73:0] p;
    logic [9:0]  sh;
    logic [1:0]  esh;
    logic [1:0]  rev;
    logic [45:0] side;
    logic [73:0] en;
    logic [1:0]  ez;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   rnd_en = 1'b0;
  bit   held = 1'b0;
  vec_t v[NV];
  vec_t cur_exp;
  vec_t exp_q[$];
  logic [73:0] h_norm;
  logic [1:0]  h_zero;
  logic [2:0]  h_cont;
  logic [45:0] h_side;

  t4_4_norm_shift_if #(.SIDE_W(46), .P_W(74)) bus ();

  t4_4_norm_shift #(.SIDE_W(46), .P_W(74)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Scoreboard: pops on output transfer, pushes on input transfer
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (bus.out_valid && !bus.out_ready) begin
        if (held) begin
          check("hold_norm", bus.norm_T4_4, h_norm);
          check("hold_side", {bus.cont_T4_4, bus.zero_T4_4, bus.side_T4_4},
                {h_cont, h_zero, h_side});
        end
        h_norm = bus.norm_T4_4;
        h_zero = bus.zero_T4_4;
        h_cont = bus.cont_T4_4;
        h_side = bus.side_T4_4;
        held = 1'b1;
      end else begin
        held = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_out: out_valid=1, expected no pending result");
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          check("norm", bus.norm_T4_4, e.en);
          check("zero", bus.zero_T4_4, e.ez);
          check("cont", bus.cont_T4_4, e.cont);
          check("side", bus.side_T4_4, e.side);
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
    end
  end

  // Random backpressure during the shuffled phase
  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic apply(input int i);
    bus.cont_T4_3     = v[i].cont;
    bus.p_reg_T4_3    = v[i].p;
    bus.sh_num_T4_3   = v[i].sh;
    bus.esh_T4_3      = v[i].esh;
    bus.revising_T4_3 = v[i].rev;
    bus.side_T4_3     = v[i].side;
    cur_exp           = v[i];
    bus.in_valid      = 1'b1;
  endtask

  task automatic drive(input int i);
    int t = 0;
    apply(i);
    @(negedge clk);
    while (!bus.in_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=0, expected 1 within 64 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit [3:0] rexp;
    int n;
    v[0]  = '{3'd0, 74'h1, 10'd20, 2'b01, 2'b00, 46'h101,
              74'h1 << 20, 2'b00};
    v[1]  = '{3'd1, {37'h3, 37'h1}, {5'd3, 5'd5}, 2'b11, 2'b10, 46'h102,
              {37'h30, 37'h20}, 2'b00};
    v[2]  = '{3'd0, 74'h1, 10'd63, 2'b01, 2'b01, 46'h103,
              74'h1 << 64, 2'b00};
    v[3]  = '{3'd0, 74'h800, 10'd63, 2'b01, 2'b00, 46'h104, 74'h0, 2'b00};
    v[4]  = '{3'd5, 74'h123, 10'd4, 2'b11, 2'b11, 46'h2A5, 74'h0, 2'b11};
    v[5]  = '{3'd2, 74'h3, 10'd10, 2'b00, 2'b01, 46'h106, 74'h6, 2'b00};
    v[6]  = '{3'd0, 74'h0, 10'd5, 2'b01, 2'b00, 46'h107, 74'h0, 2'b11};
    v[7]  = '{3'd1, {37'h0, 37'h5}, {5'd7, 5'd2}, 2'b01, 2'b00, 46'h108,
              {37'h0, 37'h14}, 2'b10};
    v[8]  = '{3'd1, {37'h0, 37'h10_0000_0000}, {5'd0, 5'd1}, 2'b01, 2'b00,
              46'h109, 74'h0, 2'b10};
    v[9]  = '{3'd1, {37'h1, 37'h1}, {5'd31, 5'd31}, 2'b11, 2'b11, 46'h10A,
              {37'h1_0000_0000, 37'h1_0000_0000}, 2'b00};
    v[10] = '{3'd0, 74'h3 << 72, 10'd1, 2'b01, 2'b00, 46'h10B,
              74'h1 << 73, 2'b00};
    v[11] = '{3'd7, 74'h0, 10'd0, 2'b00, 2'b00, 46'h3FFF_FFFF_FFFF,
              74'h0, 2'b11};
    v[12] = '{3'd1, {37'h7, 37'h9}, {5'd31, 5'd31}, 2'b00, 2'b00, 46'h10D,
              {37'h7, 37'h9}, 2'b00};
    v[13] = '{3'd0, 74'h5, 10'd30, 2'b00, 2'b00, 46'h10E, 74'h5, 2'b00};
    v[14] = '{3'd0, 74'h1, 10'h3C5, 2'b01, 2'b00, 46'h10F,
              74'h1 << 5, 2'b00};

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.cont_T4_3 = '0;
    bus.p_reg_T4_3 = '0;
    bus.sh_num_T4_3 = '0;
    bus.esh_T4_3 = '0;
    bus.revising_T4_3 = '0;
    bus.side_T4_3 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_norm", bus.norm_T4_4, 0);
    check("rst_cont_zero", {bus.cont_T4_4, bus.zero_T4_4}, 0);
    check("rst_side", bus.side_T4_4, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);

    @(posedge clk);
    #1;
    drive(0);
    check("latency_valid", bus.out_valid, 1);
    check("latency_norm", bus.norm_T4_4, 74'h1 << 20);
    drain();

    for (int i = 0; i < NV; i++) drive(i);
    drain();

    rexp = 4'b0001;
`ifdef T4_4_SKID_EN
    rexp = 4'b0011;
`endif
    bus.out_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      bit acc;
      apply(n);
      @(negedge clk);
      check($sformatf("stall_in_ready_%0d", c), bus.in_ready, rexp[c]);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) n++;
    end
    bus.out_ready = 1'b1;
    for (int i = n; i < 4; i++) drive(i);
    drain();

    rnd_en = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NV; i++) drive(i);
    rnd_en = 1'b0;
    @(posedge clk);
    #2;
    drain();

    bus.out_ready = 1'b0;
    apply(1);
    @(posedge clk);
    #1;
    apply(2);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_norm", bus.norm_T4_4, 0);
    check("mid_rst_side", bus.side_T4_4, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", bus.out_valid, 0);
      check("post_rst_ready", bus.in_ready, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
